// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rc4_pkg
// Brief   : Shared types and defaults for the RC4 key-search scheduler slice.
// Revision: 1.0
// ============================================================================
package rc4_pkg;

    localparam int          KEY_W_DEF   = 24;
    localparam logic [23:0] KEY_MIN_DEF = 24'h000000;
    localparam logic [23:0] KEY_MAX_DEF = 24'h3FFFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_FOUND     = 3'd3,
        ST_EXHAUSTED = 3'd4
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/rc4_key_search_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : rc4_key_search_scheduler_if
// Brief   : Control/status bundle between software, the scheduler and the core.
// Revision: 1.0
// ============================================================================
interface rc4_key_search_scheduler_if #(
    parameter int KEY_W = rc4_pkg::KEY_W_DEF
);
    logic             start;
    logic             abort;
    logic             core_done;
    logic             core_key_valid;
    logic             core_rst;
    logic [KEY_W-1:0] key;
    logic             busy;
    logic             found;
    logic             exhausted;
    logic [KEY_W-1:0] found_key;
    logic [KEY_W-1:0] keys_tried;
    logic             timeout_err;

    modport master (
        output start, abort, core_done, core_key_valid,
        input  core_rst, key, busy, found, exhausted, found_key, keys_tried, timeout_err
    );

    modport slave (
        input  start, abort, core_done, core_key_valid,
        output core_rst, key, busy, found, exhausted, found_key, keys_tried, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/rc4_run_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : rc4_run_watchdog
// Brief   : Counts RUN cycles of one candidate; flags the TIMEOUT_CYCLES-1 limit.
// Revision: 1.0
// ============================================================================
module rc4_run_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int                 c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    // Saturates at the limit so a stalled enable cannot wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/rc4_key_search_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : rc4_key_search_scheduler
// Brief   : Steps the RC4 controller through a key range until hit/exhaust/abort.
// Revision: 1.0
// ============================================================================
module rc4_key_search_scheduler
    import rc4_pkg::*;
#(
    parameter int               KEY_W          = KEY_W_DEF,
    parameter logic [KEY_W-1:0] KEY_MIN        = KEY_MIN_DEF,
    parameter logic [KEY_W-1:0] KEY_MAX        = KEY_MAX_DEF,
    parameter int               KEY_STEP       = 1,
    parameter int               RST_CYCLES     = 2,
    parameter int               TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    rc4_key_search_scheduler_if.slave bus
);
    localparam logic [2:0] c_st_idle      = ST_IDLE;
    localparam logic [2:0] c_st_hold      = ST_HOLD;
    localparam logic [2:0] c_st_run       = ST_RUN;
    localparam logic [2:0] c_st_found     = ST_FOUND;
    localparam logic [2:0] c_st_exhausted = ST_EXHAUSTED;

    localparam int                  c_hold_w    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RST_CYCLES - 1);
    localparam logic [KEY_W:0]      c_step_ext  = (KEY_W + 1)'(KEY_STEP);
    localparam logic [KEY_W:0]      c_max_ext   = {1'b0, KEY_MAX};

    logic [2:0]          r_state;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [KEY_W-1:0]    r_key;
    logic [KEY_W-1:0]    r_found_key;
    logic [KEY_W-1:0]    r_keys_tried;
    logic                r_found;
    logic                r_exhausted;
    logic                r_timeout_err;

    logic                w_in_run;
    logic                w_wd_expired;
    logic [KEY_W:0]      w_next_key_ext;
    logic                w_last_key;

    assign w_in_run = (r_state == c_st_run);

    // One extra bit so a step past the top of the key space reads as "done".
    assign w_next_key_ext = {1'b0, r_key} + c_step_ext;
    assign w_last_key     = (w_next_key_ext > c_max_ext);

    rc4_run_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_in_run),
        .enable  (w_in_run),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_hold_cnt    <= '0;
            r_key         <= KEY_MIN;
            r_found_key   <= '0;
            r_keys_tried  <= '0;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_found, c_st_exhausted: begin
                    if (bus.start) begin
                        r_state       <= c_st_hold;
                        r_hold_cnt    <= '0;
                        r_key         <= KEY_MIN;
                        r_keys_tried  <= '0;
                        r_found       <= 1'b0;
                        r_exhausted   <= 1'b0;
                        r_timeout_err <= 1'b0;
                    end
                end
                c_st_hold: begin
                    if (bus.abort) begin
                        r_state <= c_st_idle;
                    end else if (r_hold_cnt == c_hold_last) begin
                        r_state    <= c_st_run;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                c_st_run: begin
                    // Abort wins over a verdict; a verdict wins over the watchdog.
                    if (bus.abort) begin
                        r_state <= c_st_idle;
                    end else if (bus.core_done || w_wd_expired) begin
                        r_keys_tried <= r_keys_tried + 1'b1;
                        if (!bus.core_done) begin
                            r_timeout_err <= 1'b1;
                        end
                        if (bus.core_done && bus.core_key_valid) begin
                            r_state     <= c_st_found;
                            r_found     <= 1'b1;
                            r_found_key <= r_key;
                        end else if (w_last_key) begin
                            r_state     <= c_st_exhausted;
                            r_exhausted <= 1'b1;
                        end else begin
                            r_state <= c_st_hold;
                            r_key   <= w_next_key_ext[KEY_W-1:0];
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.core_rst    = !w_in_run;
    assign bus.busy        = (r_state == c_st_hold) || w_in_run;
    assign bus.key         = r_key;
    assign bus.found       = r_found;
    assign bus.exhausted   = r_exhausted;
    assign bus.found_key   = r_found_key;
    assign bus.keys_tried  = r_keys_tried;
    assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_rc4_key_search_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_rc4_key_search_scheduler
// Brief   : Three scheduler instances with stub cores; key order is scoreboarded.
// Revision: 1.0
// ============================================================================
module tb_rc4_key_search_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_v   [3];
    logic        abort_v   [3];
    logic [23:0] valid_key [3];
    logic [23:0] stall_key [3];

    logic        core_rst_v [3];
    logic        busy_v     [3];
    logic        found_v    [3];
    logic        exh_v      [3];
    logic        tmo_v      [3];
    logic        done_v     [3];
    logic [23:0] key_v      [3];
    logic [23:0] fkey_v     [3];
    logic [23:0] tried_v    [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] sb_q [$];

    // Instance 0: 0..7 step 1; instance 1: 1..8 step 2; instance 2: 0..3 step 1.
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam logic [23:0] C_MIN  = (gi == 1) ? 24'd1 : 24'd0;
        localparam logic [23:0] C_MAX  = (gi == 0) ? 24'd7 : ((gi == 1) ? 24'd8 : 24'd3);
        localparam int          C_STEP = (gi == 1) ? 2 : 1;

        rc4_key_search_scheduler_if #(.KEY_W(24)) bus ();
        logic [4:0] run_cnt;

        always_ff @(posedge clk) begin
            if (bus.core_rst) run_cnt <= '0;
            else if (run_cnt != 5'd31) run_cnt <= run_cnt + 5'd1;
        end

        assign bus.start          = start_v[gi];
        assign bus.abort          = abort_v[gi];
        assign bus.core_done      = !bus.core_rst && (run_cnt >= 5'd10) && (bus.key != stall_key[gi]);
        assign bus.core_key_valid = bus.core_done && (bus.key == valid_key[gi]);

        assign core_rst_v[gi] = bus.core_rst;
        assign busy_v[gi]     = bus.busy;
        assign found_v[gi]    = bus.found;
        assign exh_v[gi]      = bus.exhausted;
        assign tmo_v[gi]      = bus.timeout_err;
        assign done_v[gi]     = bus.core_done;
        assign key_v[gi]      = bus.key;
        assign fkey_v[gi]     = bus.found_key;
        assign tried_v[gi]    = bus.keys_tried;

        rc4_key_search_scheduler #(
            .KEY_W          (24),
            .KEY_MIN        (C_MIN),
            .KEY_MAX        (C_MAX),
            .KEY_STEP       (C_STEP),
            .RST_CYCLES     (2),
            .TIMEOUT_CYCLES (16)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_range(input int lo, input int hi, input int step);
        for (int k = lo; k <= hi; k += step) sb_q.push_back(24'(k));
    endtask

    task automatic pulse_start(input int idx);
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx, input int budget, input string tag);
        int n = 0;
        while (busy_v[idx] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_value(tag, 32'(busy_v[idx]), 32'd0);
    endtask

    task automatic check_final(input int idx, input string pfx, input logic ef, input logic ee,
                               input logic et, input logic [23:0] ek, input logic [23:0] en);
        check_value({pfx, "_found"},     32'(found_v[idx]),    32'(ef));
        check_value({pfx, "_exhausted"}, 32'(exh_v[idx]),      32'(ee));
        check_value({pfx, "_timeout"},   32'(tmo_v[idx]),      32'(et));
        check_value({pfx, "_key"},       32'(key_v[idx]),      32'(ek));
        check_value({pfx, "_tried"},     32'(tried_v[idx]),    32'(en));
        check_value({pfx, "_core_rst"},  32'(core_rst_v[idx]), 32'd1);
        check_value({pfx, "_sb_empty"},  32'(sb_q.size()),     32'd0);
    endtask

    task automatic check_reset_state(input string pfx);
        check_value({pfx, "_core_rst"},  32'(core_rst_v[0]), 32'd1);
        check_value({pfx, "_key"},       32'(key_v[0]),      32'd0);
        check_value({pfx, "_busy"},      32'(busy_v[0]),     32'd0);
        check_value({pfx, "_found"},     32'(found_v[0]),    32'd0);
        check_value({pfx, "_exhausted"}, 32'(exh_v[0]),      32'd0);
        check_value({pfx, "_found_key"}, 32'(fkey_v[0]),     32'd0);
        check_value({pfx, "_tried"},     32'(tried_v[0]),    32'd0);
        check_value({pfx, "_timeout"},   32'(tmo_v[0]),      32'd0);
    endtask

    // Each falling core_rst presents a candidate: pop the expected key for it.
    logic prev_crst [3] = '{1'b1, 1'b1, 1'b1};
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (prev_crst[i] && !core_rst_v[i] && !rst) begin
                if (sb_q.size() == 0) check_value("key_extra", 32'(key_v[i]), 32'hFFFF_FFFF);
                else check_value("key_seq", 32'(key_v[i]), 32'(sb_q.pop_front()));
            end
            prev_crst[i] = core_rst_v[i];
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i]   = 1'b0;
            abort_v[i]   = 1'b0;
            valid_key[i] = 24'hFFFFFF;
            stall_key[i] = 24'hFFFFFF;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("rst");
        check_value("rst_key_min_inst1", 32'(key_v[1]), 32'd1);

        // Hit on key 5
        valid_key[0] = 24'd5;
        push_range(0, 5, 1);
        pulse_start(0);
        check_value("t1_busy", 32'(busy_v[0]), 32'd1);
        wait_idle(0, 300, "t1_wait");
        check_final(0, "t1", 1'b1, 1'b0, 1'b0, 24'd5, 24'd6);
        check_value("t1_found_key", 32'(fkey_v[0]), 32'd5);

        // Reset in HOLD, then restart latency
        pulse_start(0);
        check_value("t6_in_hold", 32'(busy_v[0] & core_rst_v[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("t6");
        rst = 1'b0;
        @(negedge clk);
        push_range(0, 5, 1);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 1;
        while (core_rst_v[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_value("t6_latency", 32'(n), 32'd3);
        wait_idle(0, 300, "t6_wait");
        check_value("t6_found_key", 32'(fkey_v[0]), 32'd5);
        check_value("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        // No valid key
        valid_key[0] = 24'hFFFFFF;
        push_range(0, 7, 1);
        pulse_start(0);
        wait_idle(0, 400, "t2_wait");
        check_final(0, "t2", 1'b0, 1'b1, 1'b0, 24'd7, 24'd8);

        // Abort coinciding with a valid verdict; start in the same cycle is ignored
        valid_key[0] = 24'd5;
        push_range(0, 5, 1);
        pulse_start(0);
        n = 0;
        while (!(done_v[0] && key_v[0] == 24'd5) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_value("t5_reach_done", 32'(done_v[0]), 32'd1);
        abort_v[0] = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        start_v[0] = 1'b0;
        check_value("t5_busy",     32'(busy_v[0]),     32'd0);
        check_value("t5_found",    32'(found_v[0]),    32'd0);
        check_value("t5_core_rst", 32'(core_rst_v[0]), 32'd1);
        check_value("t5_tried",    32'(tried_v[0]),    32'd5);
        @(negedge clk);
        check_value("t5_still_idle", 32'(busy_v[0]),   32'd0);
        check_value("t5_sb_empty", 32'(sb_q.size()),   32'd0);

        // Step of 2 over 1..8
        push_range(1, 7, 2);
        pulse_start(1);
        wait_idle(1, 300, "t3_wait");
        check_final(1, "t3", 1'b0, 1'b1, 1'b0, 24'd7, 24'd4);

        // Key 2 never completes: watchdog abandons it
        stall_key[2] = 24'd2;
        push_range(0, 3, 1);
        pulse_start(2);
        wait_idle(2, 300, "t4_wait");
        check_final(2, "t4", 1'b0, 1'b1, 1'b1, 24'd3, 24'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rc4_key_search_scheduler.md
Name: rc4_key_search_scheduler

Overview:
- Brute-force key-search sequencer that sits above the per-key RC4 controller (init → shuffle A → shuffle B → decrypt).
- Presents one candidate key at a time and holds the controller in reset between candidates.
- Waits for the controller's done flag and samples its key-valid verdict.
- Steps through a programmable key range until a valid key is found, the range is exhausted, or software aborts.

Parameters:
- KEY_W, 24, key width in bits.
- KEY_MIN, 24'h000000, first candidate key.
- KEY_MAX, 24'h3FFFFF, last candidate key (inclusive upper bound).
- KEY_STEP, 1, increment between candidates; >1 allows interleaved multi-core search.
- RST_CYCLES, 2, cycles core_rst is held high per candidate (≥1).
- TIMEOUT_CYCLES, 65535, maximum RUN cycles before a candidate is abandoned.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle pulse: begin search at KEY_MIN.
- abort, in, 1, single-cycle pulse: stop search.
- core_done, in, 1, controller done level, held high in its terminal state.
- core_key_valid, in, 1, controller key-valid verdict; meaningful while core_done=1.
- core_rst, out, 1, synchronous reset to the controller.
- key, out, KEY_W, candidate key driven to the key-schedule datapath.
- busy, out, 1, search in progress.
- found, out, 1, sticky; valid key located.
- exhausted, out, 1, sticky; range searched with no hit.
- found_key, out, KEY_W, key that produced the hit.
- keys_tried, out, KEY_W, count of candidates completed.
- timeout_err, out, 1, sticky; at least one candidate timed out.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: state=IDLE, core_rst=1, key=KEY_MIN, busy=0, found=0, exhausted=0, found_key=0, keys_tried=0, timeout_err=0, watchdog=0.
- States: IDLE, HOLD, RUN, FOUND, EXHAUSTED.
- IDLE:
  - core_rst=1.
  - start → HOLD next cycle.
  - On that transition: key←KEY_MIN, keys_tried←0, found/exhausted/timeout_err←0.
- HOLD:
  - core_rst=1 for exactly RST_CYCLES cycles, counted by the hold counter; then → RUN.
  - key is stable throughout HOLD and RUN.
- RUN:
  - core_rst=0; watchdog increments each cycle.
  - First cycle with core_done=1:
    - keys_tried increments.
    - If core_key_valid=1 → FOUND, found_key←key.
    - Else if key+KEY_STEP > KEY_MAX → EXHAUSTED. The comparison is evaluated at KEY_W+1 bits, so no wrap-around.
    - Else key←key+KEY_STEP → HOLD, and the watchdog clears.
  - Watchdog reaching TIMEOUT_CYCLES−1 with core_done=0:
    - timeout_err←1; the candidate counts as failed.
    - Same advance/exhaust rule as a failed candidate.
  - core_done in the watchdog-limit cycle takes priority over the timeout.
- FOUND and EXHAUSTED:
  - Terminal; core_rst=1, busy=0, sticky flags held.
  - start re-launches exactly as from IDLE.
- busy=1 in HOLD and RUN only.
- abort:
  - In HOLD or RUN → IDLE next cycle, core_rst=1.
  - found, exhausted and keys_tried are not updated.
  - abort has priority over core_done and timeout in the same cycle.
  - Ignored in IDLE, FOUND and EXHAUSTED.
- start while busy: ignored. start and abort together in IDLE: start wins.
- KEY_MIN = KEY_MAX: one candidate only, then FOUND or EXHAUSTED.
- rst mid-search: immediate return to reset values; the controller is held in reset via core_rst=1.
- Latency, start to first core_rst deassertion: 1+RST_CYCLES cycles.
- Per-candidate overhead beyond controller runtime: RST_CYCLES+1 cycles.

Decomposition:
- Shared package rc4_pkg:
  - Scheduler state enum type.
  - KEY_W default constant.
  - Default KEY_MIN and KEY_MAX constants.
- One natural sub-module, rc4_run_watchdog:
  - Inputs: clear, enable.
  - Output: expired pulse at TIMEOUT_CYCLES−1.
- Hold counter and key incrementer stay inline.

Test Plan:
1. KEY_MIN=0, KEY_MAX=7, stub core asserts core_done after 10 RUN cycles with core_key_valid=1 only for key=5 → found=1, found_key=5, keys_tried=6, core_rst high in the FOUND state.
2. Same range, valid never asserted → exhausted=1 after key=7, keys_tried=8, found=0, key stays 7.
3. KEY_STEP=2, KEY_MIN=1, KEY_MAX=8 → keys presented 1,3,5,7; exhaust after 7 with no attempt at 9.
4. TIMEOUT_CYCLES=16, stub never asserts done for key=2, range 0..3 → timeout_err=1, search continues to key=3, keys_tried=4.
5. abort in RUN on the same cycle as core_done with core_key_valid=1 → IDLE, found=0, core_rst=1 next cycle; start pulse in that abort cycle is ignored.
6. rst asserted mid-HOLD → all outputs at reset values next cycle; subsequent start restarts at KEY_MIN with core_rst high for exactly RST_CYCLES=2 cycles.
